// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: drives the PLL reset, qualifies a synchronized lock,
// releases the downstream reset, and re-sequences on lock loss with bounded retries.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             retry_req,
    input  logic             clr_cnt,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int MAX_A   = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int TMR_MAX = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TMR_ZERO    = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(32'd1);
    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 32'sd1);
    localparam logic [TMR_W-1:0] WAIT_LAST   = TMR_W'(LOCK_TIMEOUT - 32'sd1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 32'sd1);
    localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRY);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic [7:0]       retry_r, retry_s;
    logic [CNT_W-1:0] cnt_s;
    logic             loss_s;
    logic             lock_meta_r, lock_sync_r;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Next-state, phase timer, retry and lock-loss counter logic.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        retry_s = retry_r;
        loss_s  = 1'b0;
        case (state_r)
            ST_RESET_PLL: begin
                if (timer_r == RST_LAST) begin
                    state_s = ST_WAIT_LOCK;
                    timer_s = TMR_ZERO;
                end else begin
                    timer_s = timer_r + TMR_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                // A lock seen on the timeout cycle takes priority over the retry.
                if (lock_sync_r) begin
                    state_s = ST_STABILIZE;
                    timer_s = TMR_ZERO;
                end else if (timer_r == WAIT_LAST) begin
                    timer_s = TMR_ZERO;
                    retry_s = retry_r + 8'd1;
                    if ((retry_r + 8'd1) == RETRY_LIMIT) begin
                        state_s = ST_FAULT;
                    end else begin
                        state_s = ST_RESET_PLL;
                    end
                end else begin
                    timer_s = timer_r + TMR_ONE;
                end
            end
            ST_STABILIZE: begin
                if (!lock_sync_r) begin
                    state_s = ST_WAIT_LOCK;
                    timer_s = TMR_ZERO;
                end else if (timer_r == STABLE_LAST) begin
                    state_s = ST_RUN;
                    timer_s = TMR_ZERO;
                    retry_s = 8'd0;
                end else begin
                    timer_s = timer_r + TMR_ONE;
                end
            end
            ST_RUN: begin
                if (!lock_sync_r) begin
                    state_s = ST_RESET_PLL;
                    timer_s = TMR_ZERO;
                    loss_s  = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (retry_req) begin
                    state_s = ST_RESET_PLL;
                    timer_s = TMR_ZERO;
                    retry_s = 8'd0;
                end else begin
                    state_s = ST_FAULT;
                end
            end
            default: begin
                state_s = ST_RESET_PLL;
                timer_s = TMR_ZERO;
                retry_s = 8'd0;
            end
        endcase

        // Clear applies first, so a coincident loss leaves the count at one.
        if (clr_cnt) begin
            cnt_s = loss_s ? CNT_ONE : CNT_ZERO;
        end else if (loss_s && (lock_loss_cnt != CNT_MAX)) begin
            cnt_s = lock_loss_cnt + CNT_ONE;
        end else begin
            cnt_s = lock_loss_cnt;
        end
    end

    // State register and outputs registered from the next state.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_RESET_PLL;
            timer_r       <= TMR_ZERO;
            retry_r       <= 8'd0;
            lock_loss_cnt <= CNT_ZERO;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state_r       <= state_s;
            timer_r       <= timer_s;
            retry_r       <= retry_s;
            lock_loss_cnt <= cnt_s;
            pll_rst       <= (state_s == ST_RESET_PLL) || (state_s == ST_FAULT);
            sys_rst_n     <= (state_s == ST_RUN);
            ready         <= (state_s == ST_RUN);
            fault         <= (state_s == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a phase/dwell reference model predicts
// outputs per edge into a queue; an independent monitor pops and compares.
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRY     = 2;
    localparam int CNT_W         = 2;
    localparam int CNT_SAT       = (1 << CNT_W) - 1;
    localparam int OW            = 4 + CNT_W;

    localparam int P_RST = 10, P_WAIT = 11, P_QUAL = 12, P_RUN = 13, P_FAULT = 14;

    logic             refclk = 1'b0;
    logic             rst = 1'b0;
    logic             lock_drv = 1'b0;
    logic             retry_req = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             pll_locked;
    logic             pll_rst, sys_rst_n, ready, fault;
    logic [CNT_W-1:0] lock_loss_cnt;

    int total = 0;
    int bad = 0;

    logic [OW-1:0] sb[$];

    // Reference model: phase, edges spent in phase, retries, loss count, sync pipeline.
    int m_phase, m_dwell, m_tries, m_cnt;
    bit m_hist[$];

    // A real PLL never reports lock while held in reset.
    assign pll_locked = lock_drv & ~pll_rst;

    always #5 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .retry_req(retry_req),
        .clr_cnt(clr_cnt), .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready),
        .fault(fault), .lock_loss_cnt(lock_loss_cnt)
    );

    function automatic logic [OW-1:0] model_out();
        logic [CNT_W-1:0] c;
        c = CNT_W'(m_cnt);
        return {(m_phase == P_RST || m_phase == P_FAULT), (m_phase == P_RUN),
                (m_phase == P_RUN), (m_phase == P_FAULT), c};
    endfunction

    task automatic model_reset();
        m_phase = P_RST; m_dwell = 0; m_tries = 0; m_cnt = 0;
        m_hist.delete(); m_hist.push_back(1'b0); m_hist.push_back(1'b0);
    endtask

    task automatic model_step();
        bit smp, seen, loss;
        smp  = lock_drv && !(m_phase == P_RST || m_phase == P_FAULT);
        seen = m_hist.pop_front();
        m_hist.push_back(smp);
        loss = 1'b0;
        case (m_phase)
            P_RST: begin
                m_dwell++;
                if (m_dwell == RST_CYCLES) begin m_phase = P_WAIT; m_dwell = 0; end
            end
            P_WAIT: begin
                if (seen) begin m_phase = P_QUAL; m_dwell = 0; end
                else begin
                    m_dwell++;
                    if (m_dwell == LOCK_TIMEOUT) begin
                        m_tries++;
                        m_dwell = 0;
                        m_phase = (m_tries == MAX_RETRY) ? P_FAULT : P_RST;
                    end
                end
            end
            P_QUAL: begin
                if (!seen) begin m_phase = P_WAIT; m_dwell = 0; end
                else begin
                    m_dwell++;
                    if (m_dwell == STABLE_CYCLES) begin m_phase = P_RUN; m_dwell = 0; m_tries = 0; end
                end
            end
            P_RUN: begin
                if (!seen) begin m_phase = P_RST; m_dwell = 0; loss = 1'b1; end
            end
            P_FAULT: begin
                if (retry_req) begin m_phase = P_RST; m_dwell = 0; m_tries = 0; end
            end
            default: m_phase = P_RST;
        endcase
        if (clr_cnt) m_cnt = loss ? 1 : 0;
        else if (loss) m_cnt = (m_cnt >= CNT_SAT) ? CNT_SAT : m_cnt + 1;
    endtask

    // One clock of stimulus: drive inputs at the falling edge and predict the next edge.
    task automatic tick(input logic lk, input logic rr, input logic cc);
        @(negedge refclk);
        rst = 1'b1;
        lock_drv = lk; retry_req = rr; clr_cnt = cc;
        model_step();
        sb.push_back(model_out());
    endtask

    task automatic apply_reset(input int n);
        @(negedge refclk);
        retry_req = 1'b0; clr_cnt = 1'b0;
        if (rst) begin
            rst = 1'b0;
            model_reset();
            sb.push_back(model_out());
        end
        sb.push_back(model_out());
        for (int i = 1; i < n; i++) begin
            @(negedge refclk);
            sb.push_back(model_out());
        end
    endtask

    // Monitor: after every active clock edge or reset assertion, check the oldest prediction.
    initial begin
        logic [OW-1:0] got, want;
        forever begin
            @(posedge refclk or negedge rst);
            #1;
            if (sb.size() != 0) begin
                want = sb.pop_front();
                got  = {pll_rst, sys_rst_n, ready, fault, lock_loss_cnt};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL outputs t=%0t got pll_rst,sys_rst_n,ready,fault,cnt=%b,%b,%b,%b,%0d want %b,%b,%b,%b,%0d",
                             $time, got[OW-1], got[OW-2], got[OW-3], got[OW-4], got[CNT_W-1:0],
                             want[OW-1], want[OW-2], want[OW-3], want[OW-4], want[CNT_W-1:0]);
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        model_reset();
        apply_reset(3);

        // Clean lock from release.
        repeat (30) tick(1'b1, 1'b0, 1'b0);

        // No lock: two timeouts into FAULT, then retry.
        apply_reset(2);
        repeat (65) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 1'b0);

        // Glitch during qualification.
        apply_reset(2);
        for (int i = 0; i < 100 && !(m_phase == P_QUAL && m_dwell == 5); i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        repeat (30) tick(1'b1, 1'b0, 1'b0);

        // Lock losses in RUN: saturate, clear, then clear coincident with a loss.
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            repeat (20) tick(1'b1, 1'b0, 1'b0);
        end
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        repeat (20) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        repeat (20) tick(1'b1, 1'b0, 1'b0);

        // Reset during STABILIZE and during RUN.
        for (int i = 0; i < 100 && m_phase != P_QUAL; i++) tick(1'b1, 1'b0, 1'b0);
        apply_reset(2);
        for (int i = 0; i < 100 && m_phase != P_RUN; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        apply_reset(2);
        repeat (30) tick(1'b1, 1'b0, 1'b0);

        // Lock arriving on the exact timeout edge after one prior retry.
        apply_reset(2);
        for (int i = 0; i < 200 && !(m_phase == P_WAIT && m_tries == 1 && m_dwell == LOCK_TIMEOUT - 3); i++)
            tick(1'b0, 1'b0, 1'b0);
        repeat (6) tick(1'b1, 1'b0, 1'b0);
        repeat (40) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        repeat (30) tick(1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional asynchronous reset.
        for (int i = 0; i < 4000; i++) begin
            logic lk;
            lk = lock_drv;
            if ($urandom_range(0, 29) == 0) lk = ~lk;
            if ($urandom_range(0, 799) == 0) apply_reset($urandom_range(1, 3));
            else tick(lk, ($urandom_range(0, 24) == 0), ($urandom_range(0, 59) == 0));
        end

        repeat (3) @(negedge refclk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
